// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       oper;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             zero;

    modport master (
        output in_valid, oper, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, zero
    );

    modport slave (
        input  in_valid, oper, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, zero
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake and registered result.
// Define ALU_SEQ_MUL_EN to enable the iterative shift-add multiplier on oper 110.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_BUSY = 2'b01, S_DONE = 2'b10} state_t;
    localparam int CNT_W = $clog2(WIDTH + 1);
`else
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_DONE = 2'b10} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH:0]   op_res_s;

`ifdef ALU_SEQ_MUL_EN
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
`endif

    // Single-cycle operations; returns {carry_flag, result}. 110 is the unsupported-op code.
    function automatic logic [WIDTH:0] alu_op(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y, input logic ci);
        logic [WIDTH:0] r;
        case (op)
            3'b000:  r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
            3'b001:  r = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, ci};
            3'b010:  r = {1'b0, x & y};
            3'b011:  r = {1'b0, x | y};
            3'b100:  r = {1'b0, x ^ y};
            3'b101:  r = {x[WIDTH-1], x[WIDTH-2:0], ci};
            3'b111:  r = {x[0], ci, x[WIDTH-1:1]};
            default: r = {1'b1, {WIDTH{1'b0}}};
        endcase
        return r;
    endfunction

    assign op_res_s = alu_op(bus.oper, bus.a, bus.b, bus.c_in);

    // Next-state and next-result computation for the control FSM.
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        zero_d   = zero_q;
`ifdef ALU_SEQ_MUL_EN
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (bus.oper == 3'b110) begin
                        state_d  = S_BUSY;
                        cnt_d    = {CNT_W{1'b0}};
                        acc_d    = {(2*WIDTH){1'b0}};
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                    end else begin
                        state_d = S_DONE;
                        sum_d   = op_res_s[WIDTH-1:0];
                        c_out_d = op_res_s[WIDTH];
                        zero_d  = (op_res_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    end
`else
                    state_d = S_DONE;
                    sum_d   = op_res_s[WIDTH-1:0];
                    c_out_d = op_res_s[WIDTH];
                    zero_d  = (op_res_s[WIDTH-1:0] == {WIDTH{1'b0}});
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            // WIDTH partial-product steps, then one extra edge publishes the product.
            S_BUSY: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d = S_DONE;
                    sum_d   = acc_q[WIDTH-1:0];
                    c_out_d = |acc_q[2*WIDTH-1:WIDTH];
                    zero_d  = (acc_q[WIDTH-1:0] == {WIDTH{1'b0}});
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sum_q       <= {WIDTH{1'b0}};
            c_out_q     <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            cnt_q       <= {CNT_W{1'b0}};
            acc_q       <= {(2*WIDTH){1'b0}};
            mcand_q     <= {(2*WIDTH){1'b0}};
            mplier_q    <= {WIDTH{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef ALU_SEQ_MUL_EN
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
`endif
        end
    end

    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 8-bit instance for the main function, 16-bit instance for SHL.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_seq_if #(.WIDTH(8))  bus8 ();
    alu_seq_if #(.WIDTH(16)) bus16 ();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a bundle for exactly one edge, then scramble the inputs.
    task automatic issue(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y, input logic ci);
        bus8.in_valid = 1'b1;
        bus8.oper     = op;
        bus8.a        = x;
        bus8.b        = y;
        bus8.c_in     = ci;
        step();
        bus8.in_valid = 1'b0;
        bus8.oper     = 3'b011;
        bus8.a        = 8'hFF;
        bus8.b        = 8'hFF;
        bus8.c_in     = 1'b1;
    endtask

    task automatic handshake(input string tag);
        bus8.out_ready = 1'b1;
        step();
        bus8.out_ready = 1'b0;
        chk({tag, "_idle_rdy"}, 32'(bus8.in_ready), 32'd1);
        chk({tag, "_idle_ov"}, 32'(bus8.out_valid), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus8.in_valid = 1'b0; bus8.oper = 3'b000; bus8.a = 8'h00; bus8.b = 8'h00;
        bus8.c_in = 1'b0; bus8.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.oper = 3'b000; bus16.a = 16'h0000; bus16.b = 16'h0000;
        bus16.c_in = 1'b0; bus16.out_ready = 1'b0;

        // Reset state, with in_valid high to show nothing is taken during reset.
        bus8.in_valid = 1'b1;
        step();
        step();
        chk("rst_rdy", 32'(bus8.in_ready), 32'd1);
        chk("rst_ov", 32'(bus8.out_valid), 32'd0);
        chk("rst_sum", 32'(bus8.sum), 32'h00);
        chk("rst_cout", 32'(bus8.c_out), 32'd0);
        chk("rst_zero", 32'(bus8.zero), 32'd0);
        bus8.in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // ADD 0xD2 + 0xB6 = 0x188
        issue(3'b000, 8'hD2, 8'hB6, 1'b0);
        chk("add_ov", 32'(bus8.out_valid), 32'd1);
        chk("add_sum", 32'(bus8.sum), 32'h88);
        chk("add_cout", 32'(bus8.c_out), 32'd1);
        chk("add_zero", 32'(bus8.zero), 32'd0);
        handshake("add");

        // SUB both directions
        issue(3'b001, 8'hD2, 8'hB6, 1'b0);
        chk("sub1_sum", 32'(bus8.sum), 32'h1C);
        chk("sub1_cout", 32'(bus8.c_out), 32'd0);
        handshake("sub1");
        issue(3'b001, 8'hB6, 8'hD2, 1'b0);
        chk("sub2_sum", 32'(bus8.sum), 32'hE4);
        chk("sub2_cout", 32'(bus8.c_out), 32'd1);
        handshake("sub2");

        // OR and SHR
        issue(3'b011, 8'h0F, 8'hF0, 1'b0);
        chk("or_sum", 32'(bus8.sum), 32'hFF);
        chk("or_cout", 32'(bus8.c_out), 32'd0);
        handshake("or");
        issue(3'b111, 8'h81, 8'h00, 1'b1);
        chk("shr_sum", 32'(bus8.sum), 32'hC0);
        chk("shr_cout", 32'(bus8.c_out), 32'd1);
        handshake("shr");

`ifdef ALU_SEQ_MUL_EN
        // MUL 0xD2 * 0xB6 = 0x954C
        issue(3'b110, 8'hD2, 8'hB6, 1'b1);
        for (int i = 0; i < 9; i++) begin
            chk("mul_busy_rdy", 32'(bus8.in_ready), 32'd0);
            chk("mul_busy_ov", 32'(bus8.out_valid), 32'd0);
            step();
        end
        chk("mul_ov", 32'(bus8.out_valid), 32'd1);
        chk("mul_sum", 32'(bus8.sum), 32'h4C);
        chk("mul_cout", 32'(bus8.c_out), 32'd1);
        handshake("mul");
`else
        // oper 110 unsupported: single-cycle, sum 0, c_out 1
        issue(3'b110, 8'hD2, 8'hB6, 1'b0);
        chk("nomul_ov", 32'(bus8.out_valid), 32'd1);
        chk("nomul_sum", 32'(bus8.sum), 32'h00);
        chk("nomul_cout", 32'(bus8.c_out), 32'd1);
        chk("nomul_zero", 32'(bus8.zero), 32'd1);
        handshake("nomul");
`endif

        // AND to zero, result held under back-pressure while inputs churn
        issue(3'b010, 8'h0F, 8'hF0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_ov", 32'(bus8.out_valid), 32'd1);
            chk("hold_sum", 32'(bus8.sum), 32'h00);
            chk("hold_zero", 32'(bus8.zero), 32'd1);
            chk("hold_rdy", 32'(bus8.in_ready), 32'd0);
            bus8.in_valid = ~bus8.in_valid;
            bus8.oper     = 3'b000;
            bus8.a        = 8'(8'h11 * (i + 1));
            bus8.b        = 8'h22;
            step();
        end
        bus8.in_valid = 1'b0;
        handshake("hold");
        step();
        chk("hold_noq_ov", 32'(bus8.out_valid), 32'd0);

        // Leave a non-zero sum, then reset mid-operation
        issue(3'b100, 8'h5A, 8'h0F, 1'b0);
        chk("xor_sum", 32'(bus8.sum), 32'h55);
        handshake("xor");
`ifdef ALU_SEQ_MUL_EN
        issue(3'b110, 8'hD2, 8'hB6, 1'b0);
        step();
        step();
        step();
`else
        issue(3'b100, 8'h5A, 8'h0F, 1'b0);
`endif
        rst_n = 1'b0;
        #1;
        chk("mrst_ov", 32'(bus8.out_valid), 32'd0);
        chk("mrst_sum", 32'(bus8.sum), 32'h00);
        chk("mrst_rdy", 32'(bus8.in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        step();
        chk("mrst_nores", 32'(bus8.out_valid), 32'd0);
        issue(3'b000, 8'h01, 8'h01, 1'b0);
        chk("post_rst_sum", 32'(bus8.sum), 32'h02);
        chk("post_rst_cout", 32'(bus8.c_out), 32'd0);
        handshake("post_rst");

        // 16-bit SHL 0x8001 with c_in=1
        bus16.in_valid = 1'b1;
        bus16.oper     = 3'b101;
        bus16.a        = 16'h8001;
        bus16.c_in     = 1'b1;
        step();
        bus16.in_valid = 1'b0;
        bus16.a        = 16'h0000;
        chk("shl16_ov", 32'(bus16.out_valid), 32'd1);
        chk("shl16_sum", 32'(bus16.sum), 32'h0003);
        chk("shl16_cout", 32'(bus16.c_out), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits, legal range 4..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand bundle is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand bundle.
REQ-006 The block SHALL have port oper, input, 3 bits: operation select.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-009 The block SHALL have port c_in, input, 1 bit: carry/borrow/shift-in bit.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result, registered.
REQ-013 The block SHALL have port c_out, output, 1 bit: carry/borrow/overflow flag, registered.
REQ-014 The block SHALL have port zero, output, 1 bit: high when sum equals 0, registered.

Function
REQ-015 The operations SHALL be, by oper value:
- 000 ADD: {c_out,sum} = a+b+c_in.
- 001 SUB: sum = (a-b-c_in) mod 2^WIDTH; c_out = 1 iff a < b+c_in.
- 010 AND, 011 OR, 100 XOR: bitwise result; c_out = 0.
- 101 SHL: sum = {a[WIDTH-2:0],c_in}; c_out = a[WIDTH-1].
- 110 MUL: see REQ-019.
- 111 SHR: sum = {c_in,a[WIDTH-1:1]}; c_out = a[0].
REQ-016 The control FSM SHALL have states IDLE, BUSY and DONE; in_ready SHALL be 1 exactly when the state is IDLE.
REQ-017 The block SHALL accept a bundle on a rising edge with in_valid=1 and in_ready=1; a, b, oper and c_in SHALL be latched at that edge, and later input changes SHALL have no effect on the operation.
REQ-018 For any operation other than MUL, the accept edge SHALL write sum, c_out and zero and move the FSM to DONE, so out_valid is 1 one cycle after the accept.
REQ-019 MUL SHALL be iterative shift-add: the accept edge moves the FSM to BUSY, one partial-product step is done per edge, and after WIDTH steps the edge writes sum = product[WIDTH-1:0], c_out = |product[2*WIDTH-1:WIDTH], and moves the FSM to DONE.
- out_valid therefore rises WIDTH+1 edges after the accept edge.
- c_in SHALL be ignored for MUL.
REQ-020 In DONE, out_valid SHALL be 1, and sum, c_out and zero SHALL hold stable until an edge with out_ready=1, which moves the FSM to IDLE.
REQ-021 out_valid SHALL be 0 in IDLE and in BUSY.
REQ-022 The block SHALL have no bypass: a new bundle can be accepted only in the cycle after the result handshake, so the minimum issue interval is 2 cycles.
REQ-023 in_valid asserted during BUSY or DONE SHALL be ignored and SHALL NOT be queued.
REQ-024 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-025 Overflow and borrow SHALL wrap modulo 2^WIDTH, with the overflow or borrow reported only through c_out.

Reset
REQ-026 rst_n=0 SHALL immediately force the FSM to IDLE, clear the MUL step counter and accumulator, and set sum=0, c_out=0, zero=0 and out_valid=0.
REQ-027 Reset SHALL take effect at any time, including mid-MUL; an interrupted operation SHALL be discarded and SHALL produce no result.
REQ-028 No bundle SHALL be accepted while rst_n=0; the first accept SHALL be possible on the first rising edge after rst_n returns to 1.

Configuration
REQ-029 With macro ALU_SEQ_MUL_EN defined, the block SHALL implement oper 110 as in REQ-019.
REQ-030 Without ALU_SEQ_MUL_EN, the block SHALL contain no BUSY state, step counter or accumulator, and oper 110 SHALL complete in one cycle like REQ-018 with sum=0 and c_out=1 (unsupported-op flag).

Verification
REQ-031 The bench SHALL cover, with WIDTH=8, a=0xD2, b=0xB6, oper=000, c_in=0 -> one cycle later out_valid=1, sum=0x88, c_out=1, zero=0.
REQ-032 The bench SHALL cover, with WIDTH=8, a=0xD2, b=0xB6, oper=001, c_in=0 -> sum=0x1C, c_out=0; then a=0xB6, b=0xD2 -> sum=0xE4, c_out=1.
REQ-033 The bench SHALL cover, with WIDTH=8 and ALU_SEQ_MUL_EN defined, a=0xD2, b=0xB6, oper=110 -> in_ready=0 for 9 cycles, then out_valid=1, sum=0x4C, c_out=1.
REQ-034 The bench SHALL cover oper=010 with a=0x0F, b=0xF0, holding out_ready=0 for 5 cycles while toggling in_valid and inputs -> sum=0x00 and zero=1 held stable, no second accept, and IDLE on the edge where out_ready=1.
REQ-035 The bench SHALL cover rst_n pulsed low at the 4th BUSY cycle of a MUL -> out_valid=0, sum=0 and in_ready=1 immediately; then an ADD of 0x01+0x01 gives sum=0x02.
REQ-036 The bench SHALL cover, without ALU_SEQ_MUL_EN, oper=110 -> one-cycle completion with sum=0x00 and c_out=1; and, with WIDTH=16, SHL a=0x8001, c_in=1 -> sum=0x0003, c_out=1.
